// File: rtl/mmio_gpio_bank.sv
// rtl/mmio_gpio_bank.sv - memory-mapped GPIO output bank with 64-bit cycle counter and ID
// Optional: MMIO_GPIO_IN_EN adds a two-flop synchronised gpio_in readable at idx 62.
module mmio_gpio_bank #(
   parameter int          NUM_CH     = 2,
   parameter int          CH_W       = 8,
   parameter int          IO_SEL_BIT = 22,
   parameter logic [31:0] BANK_ID    = 32'h4750_0001
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [31:0]              addr,
   input  logic [31:0]              wdata,
   input  logic [3:0]               wmask,
   input  logic                     rstrb,
`ifdef MMIO_GPIO_IN_EN
   input  logic [CH_W-1:0]          gpio_in,
`endif
   output logic [31:0]              rdata,
   output logic                     rvalid,
   output logic [NUM_CH*CH_W-1:0]   gpio_out
);

   localparam logic [3:0] NUM_CH_L = 4'(NUM_CH);

   logic [CH_W-1:0] ch_q [NUM_CH];
   logic [63:0]     cyc_q;
   logic [31:0]     shadow_q;

   logic [5:0]      idx;
   logic [3:0]      ch;
   logic [1:0]      off;
   logic            sel, wr, rd, ch_hit, cyc_wr;
   logic [31:0]     lane_mask, wbits, rd_word, in_word;
   logic [CH_W-1:0] wm, wd, cur_ch, ch_next;
   logic            unused_bits;

   assign idx    = addr[7:2];
   assign ch     = idx[5:2];
   assign off    = idx[1:0];
   assign sel    = addr[IO_SEL_BIT];
   assign wr     = sel & (|wmask);
   assign rd     = sel & rstrb;
   assign ch_hit = (idx < 6'd60) && (ch < NUM_CH_L);
   assign cyc_wr = wr && (idx == 6'd60 || idx == 6'd61);

   assign unused_bits = ^{addr, wdata};

   // Lane enables are expanded to bits; anything above CH_W falls away here.
   assign lane_mask = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
   assign wbits     = wdata & lane_mask;
   assign wm        = lane_mask[CH_W-1:0];
   assign wd        = wbits[CH_W-1:0];

   always_comb begin
      cur_ch = '0;
      for (int c = 0; c < NUM_CH; c++)
         if (ch == 4'(c)) cur_ch = ch_q[c];
   end

   always_comb begin
      ch_next = cur_ch;
      case (off)
         2'd0:    ch_next = (cur_ch & ~wm) | wd;
         2'd1:    ch_next = cur_ch | wd;
         2'd2:    ch_next = cur_ch & ~wd;
         default: ch_next = cur_ch ^ wd;
      endcase
   end

`ifdef MMIO_GPIO_IN_EN
   logic [CH_W-1:0] in_meta_q, in_sync_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         in_meta_q <= '0;
         in_sync_q <= '0;
      end else begin
         in_meta_q <= gpio_in;
         in_sync_q <= in_meta_q;
      end
   end

   assign in_word = 32'(in_sync_q);
`else
   assign in_word = '0;
`endif

   always_comb begin
      rd_word = '0;
      if (ch_hit) begin
         rd_word = 32'(cur_ch);
      end else begin
         case (idx)
            6'd60:   rd_word = cyc_q[31:0];
            6'd61:   rd_word = shadow_q;
            6'd62:   rd_word = in_word;
            6'd63:   rd_word = BANK_ID;
            default: rd_word = '0;
         endcase
      end
   end

   // Reads sample pre-edge state, so a same-cycle write is not yet visible in rdata.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdata    <= '0;
         rvalid   <= 1'b0;
         cyc_q    <= '0;
         shadow_q <= '0;
         for (int c = 0; c < NUM_CH; c++) ch_q[c] <= '0;
      end else begin
         rvalid <= 1'b0;
         cyc_q  <= cyc_wr ? 64'd0 : cyc_q + 64'd1;
         if (rd) begin
            rvalid <= 1'b1;
            rdata  <= rd_word;
            if (idx == 6'd60) shadow_q <= cyc_q[63:32];
         end
         for (int c = 0; c < NUM_CH; c++)
            if (wr && ch_hit && ch == 4'(c)) ch_q[c] <= ch_next;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign gpio_out[g*CH_W +: CH_W] = ch_q[g];
   end

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// tb/tb_mmio_gpio_bank.sv - directed self-checking bench for mmio_gpio_bank
// Build with MMIO_GPIO_IN_EN defined to exercise the gpio_in path.
module tb_mmio_gpio_bank;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wmask = '0;
   logic        rstrb = 1'b0;
   logic [31:0] rdata;
   logic        rvalid;
   logic [15:0] gpio_out;
`ifdef MMIO_GPIO_IN_EN
   logic [7:0]  gpio_in = '0;
`endif

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] IO = 32'h0040_0000;

   mmio_gpio_bank dut (
      .clk      (clk),
      .rstn     (rstn),
      .addr     (addr),
      .wdata    (wdata),
      .wmask    (wmask),
      .rstrb    (rstrb),
`ifdef MMIO_GPIO_IN_EN
      .gpio_in  (gpio_in),
`endif
      .rdata    (rdata),
      .rvalid   (rvalid),
      .gpio_out (gpio_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] a(input int i);
      return IO | 32'(i << 2);
   endfunction

   task automatic cycle(input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] wm,
                        input logic rs);
      @(negedge clk);
      addr = ad; wdata = wd; wmask = wm; rstrb = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle('0, '0, 4'b0000, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gpio", 64'(gpio_out), 64'h0);
      chk("rst_rdata", 64'(rdata), 64'h0);
      chk("rst_rvalid", 64'(rvalid), 64'h0);
      @(negedge clk);
      rstn = 1'b1;

      cycle(a(0), 32'h0000_005A, 4'b0001, 1'b0);
      chk("wr_ch0", 64'(gpio_out), 64'h005A);
      chk("wr_no_rvalid", 64'(rvalid), 64'h0);
      cycle(a(4), 32'h0000_000F, 4'b0001, 1'b0);
      chk("wr_ch1", 64'(gpio_out), 64'h0F5A);
      cycle(a(5), 32'h0000_00F0, 4'b0001, 1'b0);
      chk("set_ch1", 64'(gpio_out), 64'hFF5A);
      cycle(a(6), 32'h0000_003C, 4'b0001, 1'b0);
      chk("clr_ch1", 64'(gpio_out), 64'hC35A);
      cycle(a(7), 32'h0000_00FF, 4'b0001, 1'b0);
      chk("tgl_ch1", 64'(gpio_out), 64'h3C5A);
      cycle(a(4), 32'h0000_0000, 4'b0000, 1'b0);
      chk("wm0_nochg", 64'(gpio_out), 64'h3C5A);
      cycle(a(4), 32'h0000_FF00, 4'b0010, 1'b0);
      chk("lane1_nochg", 64'(gpio_out), 64'h3C5A);

      cycle(a(7), '0, 4'b0000, 1'b1);
      chk("rd_tgl_valid", 64'(rvalid), 64'h1);
      chk("rd_tgl_data", 64'(rdata), 64'h3C);
      cycle(a(63), '0, 4'b0000, 1'b1);
      chk("rd_id_valid", 64'(rvalid), 64'h1);
      chk("rd_id_data", 64'(rdata), 64'h4750_0001);
      idle();
      chk("rd_drop", 64'(rvalid), 64'h0);
      chk("rd_hold", 64'(rdata), 64'h4750_0001);

      cycle(a(0), 32'h0000_0011, 4'b0001, 1'b1);
      chk("rw_old", 64'(rdata), 64'h5A);
      chk("rw_gpio", 64'(gpio_out), 64'h3C11);
      cycle(a(0), '0, 4'b0000, 1'b1);
      chk("rw_new", 64'(rdata), 64'h11);

      cycle(32'h0000_0000, 32'h0000_00AA, 4'b0001, 1'b1);
      chk("nonio_gpio", 64'(gpio_out), 64'h3C11);
      chk("nonio_rvalid", 64'(rvalid), 64'h0);

      cycle(a(8), 32'h0000_0077, 4'b0001, 1'b1);
      chk("unmap_valid", 64'(rvalid), 64'h1);
      chk("unmap_data", 64'(rdata), 64'h0);
      chk("unmap_gpio", 64'(gpio_out), 64'h3C11);
      cycle(a(63), 32'h1234_5678, 4'b1111, 1'b0);
      cycle(a(63), '0, 4'b0000, 1'b1);
      chk("id_ro", 64'(rdata), 64'h4750_0001);

`ifdef MMIO_GPIO_IN_EN
      @(negedge clk);
      gpio_in = 8'hA5;
      idle();
      idle();
      cycle(a(62), '0, 4'b0000, 1'b1);
      chk("in_read", 64'(rdata), 64'hA5);
`else
      cycle(a(62), '0, 4'b0000, 1'b1);
      chk("in_valid", 64'(rvalid), 64'h1);
      chk("in_zero", 64'(rdata), 64'h0);
`endif

      @(negedge clk);
      force dut.cyc_q = 64'h0000_0000_FFFF_FFFE;
      addr = a(60); wdata = '0; wmask = 4'b0000; rstrb = 1'b1;
      @(posedge clk);
      #1;
      release dut.cyc_q;
      chk("cyc_lo_a", 64'(rdata), 64'hFFFF_FFFE);
      cycle(a(61), '0, 4'b0000, 1'b1);
      chk("cyc_hi_a", 64'(rdata), 64'h0);

      @(negedge clk);
      force dut.cyc_q = 64'h0000_0001_0000_0000;
      addr = a(60); rstrb = 1'b1;
      @(posedge clk);
      #1;
      release dut.cyc_q;
      chk("cyc_lo_b", 64'(rdata), 64'h0);
      cycle(a(61), '0, 4'b0000, 1'b1);
      chk("cyc_hi_b", 64'(rdata), 64'h1);

      // Cleared at the write edge, then two idle edges: the read edge samples 2.
      cycle(a(60), '0, 4'b1111, 1'b0);
      idle();
      idle();
      cycle(a(60), '0, 4'b0000, 1'b1);
      chk("cyc_clr_lo", 64'(rdata), 64'h2);
      cycle(a(61), '0, 4'b0000, 1'b1);
      chk("cyc_clr_hi", 64'(rdata), 64'h0);

      cycle(a(63), '0, 4'b0000, 1'b1);
      chk("mid_rd_valid", 64'(rvalid), 64'h1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_rvalid", 64'(rvalid), 64'h0);
      chk("mid_rst_rdata", 64'(rdata), 64'h0);
      chk("mid_rst_gpio", 64'(gpio_out), 64'h0);

      @(negedge clk);
      rstn = 1'b1;
      addr = a(60); wdata = '0; wmask = 4'b0000; rstrb = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_valid", 64'(rvalid), 64'h1);
      chk("post_rst_cyc", 64'(rdata), 64'h0);
      cycle(a(1), 32'h0000_0081, 4'b0001, 1'b0);
      chk("post_rst_set", 64'(gpio_out), 64'h0081);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
